// File: rtl/seg_scan_ctrl_if.sv
// Display-data load side and scan outputs of the seven-segment scan controller.
// master = value producer / observer, slave = seg_scan_ctrl.
interface seg_scan_ctrl_if;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  blank_in;
  logic        lz_en;
  logic [3:0]  digit_val;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;
  logic        upd_pending;

  modport master (
    output load, data_in, blank_in, lz_en,
    input  digit_val, an, digit_idx, frame_done, upd_pending
  );

  modport slave (
    input  load, data_in, blank_in, lz_en,
    output digit_val, an, digit_idx, frame_done, upd_pending
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment scan with frame-aligned double-buffered
// display data, per-digit blanking and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int SHOW_CYC = 50000,
  parameter int GAP_CYC  = 500,
  parameter int CW       = 20
) (
  input logic            clk,
  input logic            reset,
  seg_scan_ctrl_if.slave bus
);
  // state | meaning
  // SHOW  | anode of digit_idx low (unless dark), its nibble on digit_val
  // GAP   | all anodes off, digit_val held; never entered when GAP_CYC = 0

  typedef enum logic {SHOW = 1'b0, GAP = 1'b1} state_t;

  localparam bit             HAS_GAP   = (GAP_CYC > 0);
  localparam logic [CW-1:0]  SHOW_LAST = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0]  GAP_LAST  = CW'(HAS_GAP ? GAP_CYC - 1 : 0);

  state_t        state, state_n;
  logic [1:0]    idx_q, idx_n;
  logic [CW-1:0] cnt_q, cnt_n;

  logic [15:0]   shadow_word, shadow_word_n;
  logic [3:0]    shadow_mask, shadow_mask_n;
  logic          shadow_lz, shadow_lz_n;
  logic [15:0]   pend_word, pend_word_n;
  logic [3:0]    pend_mask, pend_mask_n;
  logic          pend_lz, pend_lz_n;
  logic          upd_q, upd_n;

  logic [3:0]    an_q, an_n;
  logic [3:0]    dval_q, dval_n;
  logic          fdone_q, fdone_n;

  logic          slot_end;
  logic          boundary;
  logic          lz3, lz2, lz1;
  logic [3:0]    dark;

  always_comb begin
    state_n       = state;
    idx_n         = idx_q;
    cnt_n         = cnt_q + CW'(1);
    shadow_word_n = shadow_word;
    shadow_mask_n = shadow_mask;
    shadow_lz_n   = shadow_lz;
    pend_word_n   = pend_word;
    pend_mask_n   = pend_mask;
    pend_lz_n     = pend_lz;
    upd_n         = upd_q;

    slot_end = (state == SHOW) ? (cnt_q == SHOW_LAST) : (cnt_q == GAP_LAST);
    boundary = slot_end && (idx_q == 2'd3) && ((state == GAP) || !HAS_GAP);

    if (slot_end) begin
      cnt_n = '0;
      if ((state == SHOW) && HAS_GAP) begin
        state_n = GAP;
      end else begin
        state_n = SHOW;
        idx_n   = idx_q + 2'd1;
      end
    end

    // A load landing on the boundary goes straight to the shadow so it is not
    // delayed by a whole frame.
    if (boundary) begin
      if (bus.load) begin
        shadow_word_n = bus.data_in;
        shadow_mask_n = bus.blank_in;
        shadow_lz_n   = bus.lz_en;
      end else if (upd_q) begin
        shadow_word_n = pend_word;
        shadow_mask_n = pend_mask;
        shadow_lz_n   = pend_lz;
      end
      upd_n = 1'b0;
    end else if (bus.load) begin
      pend_word_n = bus.data_in;
      pend_mask_n = bus.blank_in;
      pend_lz_n   = bus.lz_en;
      upd_n       = 1'b1;
    end

    lz3  = shadow_lz_n && (shadow_word_n[15:12] == 4'h0);
    lz2  = lz3 && (shadow_word_n[11:8] == 4'h0);
    lz1  = lz2 && (shadow_word_n[7:4] == 4'h0);
    dark = shadow_mask_n | {lz3, lz2, lz1, 1'b0};

    // Outputs are computed from the next state so they line up with digit_idx.
    an_n   = 4'b1111;
    dval_n = dval_q;
    if (state_n == SHOW) begin
      dval_n = shadow_word_n[{idx_n, 2'b00} +: 4];
      if (!dark[idx_n]) an_n[idx_n] = 1'b0;
    end

    fdone_n = (idx_n == 2'd3) &&
              (HAS_GAP ? ((state_n == GAP) && (cnt_n == GAP_LAST)) : (cnt_n == SHOW_LAST));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SHOW;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      shadow_word <= 16'h0;
      shadow_mask <= 4'h0;
      shadow_lz   <= 1'b0;
      pend_word   <= 16'h0;
      pend_mask   <= 4'h0;
      pend_lz     <= 1'b0;
      upd_q       <= 1'b0;
      an_q        <= 4'b1111;
      dval_q      <= 4'h0;
      fdone_q     <= 1'b0;
    end else begin
      state       <= state_n;
      idx_q       <= idx_n;
      cnt_q       <= cnt_n;
      shadow_word <= shadow_word_n;
      shadow_mask <= shadow_mask_n;
      shadow_lz   <= shadow_lz_n;
      pend_word   <= pend_word_n;
      pend_mask   <= pend_mask_n;
      pend_lz     <= pend_lz_n;
      upd_q       <= upd_n;
      an_q        <= an_n;
      dval_q      <= dval_n;
      fdone_q     <= fdone_n;
    end
  end

  assign bus.digit_val   = dval_q;
  assign bus.an          = an_q;
  assign bus.digit_idx   = idx_q;
  assign bus.frame_done  = fdone_q;
  assign bus.upd_pending = upd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: one instance with a gap cycle, one without, each tracked
// by a cycle-count based reference model.
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_scan_ctrl_if a();
  seg_scan_ctrl_if b();

  seg_scan_ctrl #(.SHOW_CYC(4), .GAP_CYC(1), .CW(4)) dut_a (.clk(clk), .reset(reset), .bus(a));
  seg_scan_ctrl #(.SHOW_CYC(4), .GAP_CYC(0), .CW(4)) dut_b (.clk(clk), .reset(reset), .bus(b));

  typedef struct packed {
    logic [31:0] t;
    logic [15:0] sw;
    logic [3:0]  sm;
    logic        sl;
    logic [15:0] pw;
    logic [3:0]  pm;
    logic        pl;
    logic        pf;
    logic [3:0]  dv;
    logic [3:0]  an;
    logic [1:0]  idx;
    logic        fd;
  } mdl_t;

  mdl_t ma, mb;
  int   n_checks = 0;
  int   n_pass   = 0;

  // t = cycles since the reset edge; slot position follows from plain division.
  function automatic mdl_t mdl_step(input mdl_t m, input int s, input int g, input logic rst,
                                    input logic ld, input logic [15:0] d,
                                    input logic [3:0] bl, input logic lz);
    mdl_t r;
    int f, slot, pos;
    logic [15:0] hi;
    r = m;
    f = 4 * (s + g);
    if (rst) begin
      r = '0;
      r.an = 4'hF;
      return r;
    end
    if (int'(m.t) % f == f - 1) begin
      if (ld) begin r.sw = d; r.sm = bl; r.sl = lz; end
      else if (m.pf) begin r.sw = m.pw; r.sm = m.pm; r.sl = m.pl; end
      r.pf = 1'b0;
    end else if (ld) begin
      r.pw = d; r.pm = bl; r.pl = lz; r.pf = 1'b1;
    end
    r.t   = m.t + 32'd1;
    slot  = (int'(r.t) / (s + g)) % 4;
    pos   = int'(r.t) % (s + g);
    r.idx = 2'(slot);
    r.fd  = (int'(r.t) % f) == f - 1;
    r.an  = 4'hF;
    if (pos < s) begin
      hi   = r.sw >> (4 * slot);
      r.dv = hi[3:0];
      if (!r.sm[slot] && !(r.sl && slot > 0 && hi == 16'h0)) r.an[slot] = 1'b0;
    end
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    ma = mdl_step(ma, 4, 1, reset, a.load, a.data_in, a.blank_in, a.lz_en);
    mb = mdl_step(mb, 4, 0, reset, b.load, b.data_in, b.blank_in, b.lz_en);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    n_checks++; if (a.an !== 4'hF) $display("FAIL reset_an got %h want f", a.an); else n_pass++;
    n_checks++; if (a.digit_idx !== 2'd0) $display("FAIL reset_idx got %0d want 0", a.digit_idx); else n_pass++;
    n_checks++; if (a.digit_val !== 4'h0) $display("FAIL reset_dval got %h want 0", a.digit_val); else n_pass++;
    n_checks++; if (a.frame_done !== 1'b0) $display("FAIL reset_fdone got %b want 0", a.frame_done); else n_pass++;
    n_checks++; if (a.upd_pending !== 1'b0) $display("FAIL reset_pend got %b want 0", a.upd_pending); else n_pass++;
    n_checks++; if (b.an !== 4'hF) $display("FAIL reset_an_b got %h want f", b.an); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int last_fd = -1;
    a.load = 1'b1; a.data_in = 16'h1234; a.blank_in = 4'h0; a.lz_en = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      a.load = 1'b0;
      n_checks++;
      if ({a.an, a.digit_val, a.digit_idx, a.frame_done, a.upd_pending} !== {ma.an, ma.dv, ma.idx, ma.fd, ma.pf})
        $display("FAIL basic cyc %0d got an=%b dv=%h idx=%0d fd=%b pend=%b want an=%b dv=%h idx=%0d fd=%b pend=%b",
                 i, a.an, a.digit_val, a.digit_idx, a.frame_done, a.upd_pending, ma.an, ma.dv, ma.idx, ma.fd, ma.pf);
      else n_pass++;
      if (a.frame_done) begin
        if (last_fd >= 0) begin
          n_checks++;
          if (i - last_fd != 20) $display("FAIL basic_frame_len got %0d want 20", i - last_fd); else n_pass++;
        end
        last_fd = i;
      end
    end
  endtask

  task automatic test_lz();
    logic [15:0] words [2];
    bit seen [16];
    words[0] = 16'h00A5;
    words[1] = 16'h0000;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 16; k++) seen[k] = 1'b0;
      a.load = 1'b1; a.data_in = words[w]; a.blank_in = 4'h0; a.lz_en = 1'b1;
      for (int i = 0; i < 45; i++) begin
        cycle();
        a.load = 1'b0;
        n_checks++;
        if ({a.an, a.digit_val, a.digit_idx, a.frame_done, a.upd_pending} !== {ma.an, ma.dv, ma.idx, ma.fd, ma.pf})
          $display("FAIL lz w%0d cyc %0d got an=%b dv=%h idx=%0d want an=%b dv=%h idx=%0d",
                   w, i, a.an, a.digit_val, a.digit_idx, ma.an, ma.dv, ma.idx);
        else n_pass++;
        if (i >= 21) seen[a.an] = 1'b1;
      end
      n_checks++;
      if (seen[4'b0111] || seen[4'b1011]) $display("FAIL lz_upper_dark w%0d got lit want dark", w); else n_pass++;
      n_checks++;
      if (seen[4'b1101] !== (w == 0)) $display("FAIL lz_digit1 w%0d got %b want %b", w, seen[4'b1101], w == 0); else n_pass++;
      n_checks++;
      if (!seen[4'b1110]) $display("FAIL lz_digit0 w%0d got dark want lit", w); else n_pass++;
    end
  endtask

  task automatic test_last_wins();
    int k = 0;
    bit one_shown = 1'b0;
    while (a.digit_idx != 2'd1 && k < 40) begin cycle(); k++; end
    n_checks++; if (a.digit_idx != 2'd1) $display("FAIL lw_wait got idx %0d want 1", a.digit_idx); else n_pass++;
    a.load = 1'b1; a.data_in = 16'h1111; a.blank_in = 4'h0; a.lz_en = 1'b0;
    cycle();
    a.load = 1'b0;
    n_checks++; if (a.upd_pending !== 1'b1) $display("FAIL lw_pend got %b want 1", a.upd_pending); else n_pass++;
    cycle();
    a.load = 1'b1; a.data_in = 16'h2222;
    for (int i = 0; i < 45; i++) begin
      cycle();
      a.load = 1'b0;
      n_checks++;
      if ({a.an, a.digit_val, a.digit_idx, a.frame_done, a.upd_pending} !== {ma.an, ma.dv, ma.idx, ma.fd, ma.pf})
        $display("FAIL lw cyc %0d got an=%b dv=%h pend=%b want an=%b dv=%h pend=%b",
                 i, a.an, a.digit_val, a.upd_pending, ma.an, ma.dv, ma.pf);
      else n_pass++;
      if (a.an != 4'hF && a.digit_val == 4'h1) one_shown = 1'b1;
    end
    n_checks++; if (one_shown) $display("FAIL lw_one_shown got 1 want 0"); else n_pass++;
  endtask

  task automatic test_boundary_load();
    int k = 0;
    logic [15:0] w;
    w = 16'hBEEF;
    while (!a.frame_done && k < 40) begin cycle(); k++; end
    n_checks++; if (!a.frame_done) $display("FAIL bl_wait got fd 0 want 1"); else n_pass++;
    a.load = 1'b1; a.data_in = w; a.blank_in = 4'h0; a.lz_en = 1'b0;
    cycle();
    a.load = 1'b0;
    n_checks++; if (a.upd_pending !== 1'b0) $display("FAIL bl_pend got %b want 0", a.upd_pending); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({a.an, a.digit_val, a.digit_idx, a.frame_done, a.upd_pending} !== {ma.an, ma.dv, ma.idx, ma.fd, ma.pf})
        $display("FAIL bl cyc %0d got an=%b dv=%h idx=%0d want an=%b dv=%h idx=%0d",
                 i, a.an, a.digit_val, a.digit_idx, ma.an, ma.dv, ma.idx);
      else n_pass++;
      if (a.an != 4'hF) begin
        n_checks++;
        if (a.digit_val !== w[{a.digit_idx, 2'b00} +: 4])
          $display("FAIL bl_nibble idx %0d got %h want %h", a.digit_idx, a.digit_val, w[{a.digit_idx, 2'b00} +: 4]);
        else n_pass++;
      end
      cycle();
    end
  endtask

  task automatic test_no_gap();
    int last_fd = -1;
    int dark_cyc = 0;
    b.load = 1'b1; b.data_in = 16'h1234; b.blank_in = 4'h0; b.lz_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      b.load = 1'b0;
      n_checks++;
      if ({b.an, b.digit_val, b.digit_idx, b.frame_done, b.upd_pending} !== {mb.an, mb.dv, mb.idx, mb.fd, mb.pf})
        $display("FAIL nogap cyc %0d got an=%b dv=%h idx=%0d fd=%b want an=%b dv=%h idx=%0d fd=%b",
                 i, b.an, b.digit_val, b.digit_idx, b.frame_done, mb.an, mb.dv, mb.idx, mb.fd);
      else n_pass++;
      if (b.an == 4'hF) dark_cyc++;
      if (b.frame_done) begin
        n_checks++;
        if (b.digit_idx !== 2'd3) $display("FAIL nogap_fd_idx got %0d want 3", b.digit_idx); else n_pass++;
        if (last_fd >= 0) begin
          n_checks++;
          if (i - last_fd != 16) $display("FAIL nogap_frame_len got %0d want 16", i - last_fd); else n_pass++;
        end
        last_fd = i;
      end
    end
    n_checks++; if (dark_cyc != 0) $display("FAIL nogap_dark got %0d want 0", dark_cyc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    while (!a.frame_done && k < 40) begin cycle(); k++; end
    cycle();
    a.load = 1'b1; a.data_in = 16'h5A5A; a.blank_in = 4'h0; a.lz_en = 1'b0;
    cycle();
    a.load = 1'b0;
    k = 0;
    while (!(a.digit_idx == 2'd2 && a.an != 4'hF) && k < 20) begin cycle(); k++; end
    n_checks++;
    if (!(a.digit_idx == 2'd2 && a.upd_pending)) $display("FAIL rm_wait got idx %0d pend %b want 2 1", a.digit_idx, a.upd_pending);
    else n_pass++;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++; if (a.an !== 4'hF) $display("FAIL rm_an got %b want 1111", a.an); else n_pass++;
    n_checks++; if (a.digit_idx !== 2'd0) $display("FAIL rm_idx got %0d want 0", a.digit_idx); else n_pass++;
    n_checks++; if (a.upd_pending !== 1'b0) $display("FAIL rm_pend got %b want 0", a.upd_pending); else n_pass++;
    for (int i = 0; i < 25; i++) begin
      cycle();
      n_checks++;
      if ({a.an, a.digit_val, a.digit_idx, a.frame_done, a.upd_pending} !== {ma.an, ma.dv, ma.idx, ma.fd, ma.pf})
        $display("FAIL rm cyc %0d got an=%b dv=%h idx=%0d want an=%b dv=%h idx=%0d",
                 i, a.an, a.digit_val, a.digit_idx, ma.an, ma.dv, ma.idx);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 199) == 0);
      a.load = ($urandom_range(0, 7) == 0);
      a.data_in  = 16'($urandom);
      a.blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      a.lz_en    = 1'($urandom);
      b.load = ($urandom_range(0, 7) == 0);
      b.data_in  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      b.blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      b.lz_en    = 1'($urandom);
      cycle();
      n_checks++;
      if ({a.an, a.digit_val, a.digit_idx, a.frame_done, a.upd_pending} !== {ma.an, ma.dv, ma.idx, ma.fd, ma.pf})
        $display("FAIL rand_a cyc %0d got an=%b dv=%h idx=%0d fd=%b pend=%b want an=%b dv=%h idx=%0d fd=%b pend=%b",
                 i, a.an, a.digit_val, a.digit_idx, a.frame_done, a.upd_pending, ma.an, ma.dv, ma.idx, ma.fd, ma.pf);
      else n_pass++;
      n_checks++;
      if ({b.an, b.digit_val, b.digit_idx, b.frame_done, b.upd_pending} !== {mb.an, mb.dv, mb.idx, mb.fd, mb.pf})
        $display("FAIL rand_b cyc %0d got an=%b dv=%h idx=%0d fd=%b pend=%b want an=%b dv=%h idx=%0d fd=%b pend=%b",
                 i, b.an, b.digit_val, b.digit_idx, b.frame_done, b.upd_pending, mb.an, mb.dv, mb.idx, mb.fd, mb.pf);
      else n_pass++;
      n_checks++;
      if ($countones(~a.an) > 1 || $countones(~b.an) > 1)
        $display("FAIL rand_onehot cyc %0d got an_a=%b an_b=%b want at most one low", i, a.an, b.an);
      else n_pass++;
    end
    reset  = 1'b0;
    a.load = 1'b0;
    b.load = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ma = '0;
    mb = '0;
    a.load = 1'b0; a.data_in = 16'h0; a.blank_in = 4'h0; a.lz_en = 1'b0;
    b.load = 1'b0; b.data_in = 16'h0; b.blank_in = 4'h0; b.lz_en = 1'b0;
    test_reset();
    test_basic();
    test_lz();
    test_last_wins();
    test_boundary_load();
    test_no_gap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
